// File: rtl/parity_stream_acc.sv
// ============================================================================
//  Module   : parity_stream_acc
//  Purpose  : Streaming parity checker/generator. Reports parity per beat or
//             accumulates it over a packet, behind one registered output slot.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_stream_acc #(
    parameter int WIDTH   = 8,
    parameter bit ODD     = 1'b0,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_parity,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] c_cnt_one = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_cnt_max = {COUNT_W{1'b1}};

    state_t               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 pkt_mode_q, pkt_mode_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_parity_q, out_parity_d;
    logic [COUNT_W-1:0]   out_count_q, out_count_d;

    logic                 w_accept;
    logic                 w_beat_xor;
    logic                 w_acc_next;
    logic [COUNT_W-1:0]   w_cnt_next;

    // The output slot frees up in the same cycle it is popped, so a new
    // result can land with no bubble.
    assign in_ready   = !out_valid_q || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_beat_xor = ^in_data;
    assign w_acc_next = acc_q ^ w_beat_xor;
    assign w_cnt_next = (cnt_q == c_cnt_max) ? cnt_q : (cnt_q + c_cnt_one);

    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_count  = out_count_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        pkt_mode_d   = pkt_mode_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_parity_d = out_parity_q;
        out_count_d  = out_count_q;

        if (w_accept) begin
            case (state_q)
                S_IDLE: begin
                    pkt_mode_d = mode;
                    if (!mode || in_last) begin
                        out_valid_d  = 1'b1;
                        out_parity_d = w_beat_xor ^ ODD;
                        out_count_d  = c_cnt_one;
                    end else begin
                        acc_d   = w_beat_xor;
                        cnt_d   = c_cnt_one;
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    // pkt_mode_q is always set here; closing on a clear value
                    // keeps a corrupted latch from wedging the packet open.
                    if (in_last || !pkt_mode_q) begin
                        out_valid_d  = 1'b1;
                        out_parity_d = w_acc_next ^ ODD;
                        out_count_d  = w_cnt_next;
                        acc_d        = 1'b0;
                        cnt_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        acc_d = w_acc_next;
                        cnt_d = w_cnt_next;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            pkt_mode_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pkt_mode_q   <= pkt_mode_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_count_q  <= out_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_parity_stream_acc.sv
// ============================================================================
//  Module   : tb_parity_stream_acc
//  Purpose  : Self-checking bench for parity_stream_acc (three configurations
//             driven from one shared stimulus stream).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parity_stream_acc;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       rdy0, rdy1, rdy2;
    logic       ov0, ov1, ov2;
    logic       op0, op1, op2;
    logic [7:0] oc0, oc1;
    logic [1:0] oc2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the slot contents plus the raw beats of the open packet.
    bit         m_valid;
    bit         m_par;
    int         m_len;
    bit         m_open;
    logic [7:0] m_beats[$];

    parity_stream_acc #(.WIDTH(8), .ODD(1'b0), .COUNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
        .out_parity(op0), .out_count(oc0));

    parity_stream_acc #(.WIDTH(8), .ODD(1'b1), .COUNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_parity(op1), .out_count(oc1));

    parity_stream_acc #(.WIDTH(8), .ODD(1'b0), .COUNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
        .out_parity(op2), .out_count(oc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_emit();
        int ones = 0;
        foreach (m_beats[i]) ones += $countones(m_beats[i]);
        m_par   = bit'(ones % 2);
        m_len   = m_beats.size();
        m_valid = 1'b1;
        m_open  = 1'b0;
        m_beats.delete();
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_par   = 1'b0;
        m_len   = 0;
        m_open  = 1'b0;
        m_beats.delete();
    endtask

    task automatic check_outputs();
        chk("out_valid0", int'(ov0), int'(m_valid));
        chk("out_valid1", int'(ov1), int'(m_valid));
        chk("out_valid2", int'(ov2), int'(m_valid));
        if (m_valid) begin
            chk("parity_even", int'(op0), int'(m_par));
            chk("parity_odd",  int'(op1), int'(!m_par));
            chk("parity_cw2",  int'(op2), int'(m_par));
            chk("count_cw8",   int'(oc0), (m_len > 255) ? 255 : m_len);
            chk("count_odd",   int'(oc1), (m_len > 255) ? 255 : m_len);
            chk("count_cw2",   int'(oc2), (m_len > 3) ? 3 : m_len);
        end
    endtask

    // One clock: drive at the falling edge, clock, then check at the next fall.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l,
                         input bit md, input bit r, output bit rdy_seen);
        bit take;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        mode      = md;
        out_ready = r;
        #1;
        rdy_seen = rdy0;
        chk("in_ready0", int'(rdy0), int'(!m_valid || r));
        chk("in_ready2", int'(rdy2), int'(!m_valid || r));
        take = v && (!m_valid || r);
        @(posedge clk);
        if (m_valid && r) m_valid = 1'b0;
        if (take) begin
            m_beats.push_back(d);
            if (m_open) begin
                if (l) model_emit();
            end else if (!md || l) begin
                model_emit();
            end else begin
                m_open = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid",  int'(ov0 | ov1 | ov2), 0);
        chk("rst_parity", int'(op0 | op1 | op2), 0);
        chk("rst_count",  int'(oc0 | oc1 | {6'd0, oc2}), 0);
        chk("rst_ready",  int'(rdy0 & rdy1 & rdy2), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         l;
        bit         md;
        bit         r;
        bit         exp_rdy;
        bit         exp_v;
        bit         exp_p;
        int         exp_c;
    } vec_t;

    initial begin
        vec_t vt[$];
        bit   rs;

        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_valid", int'(ov0), 0);
        chk("init_ready", int'(rdy0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        //        v  data   l  md r  rdy ov op cnt
        vt.push_back('{1, 8'hA5, 0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{1, 8'h07, 0, 0, 1, 1, 1, 1, 1});
        vt.push_back('{1, 8'h00, 0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{0, 8'h00, 0, 0, 1, 1, 0, 0, 0});
        vt.push_back('{1, 8'h01, 0, 1, 1, 1, 0, 0, 0});
        vt.push_back('{1, 8'h03, 0, 0, 1, 1, 0, 0, 0});
        vt.push_back('{1, 8'h07, 1, 0, 1, 1, 1, 0, 3});
        vt.push_back('{0, 8'h00, 0, 0, 1, 1, 0, 0, 0});
        vt.push_back('{1, 8'hFF, 1, 1, 1, 1, 1, 0, 1});
        vt.push_back('{0, 8'h00, 0, 0, 1, 1, 0, 0, 0});
        vt.push_back('{1, 8'h07, 0, 0, 0, 1, 1, 1, 1});
        vt.push_back('{1, 8'h03, 0, 0, 0, 0, 1, 1, 1});
        vt.push_back('{1, 8'h03, 0, 0, 0, 0, 1, 1, 1});
        vt.push_back('{1, 8'h03, 0, 0, 0, 0, 1, 1, 1});
        vt.push_back('{1, 8'h03, 0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{0, 8'h00, 0, 0, 1, 1, 0, 0, 0});

        foreach (vt[i]) begin
            cycle(vt[i].v, vt[i].d, vt[i].l, vt[i].md, vt[i].r, rs);
            chk($sformatf("vec%0d_ready", i), int'(rs), int'(vt[i].exp_rdy));
            chk($sformatf("vec%0d_valid", i), int'(ov0), int'(vt[i].exp_v));
            if (vt[i].exp_v) begin
                chk($sformatf("vec%0d_par_even", i), int'(op0), int'(vt[i].exp_p));
                chk($sformatf("vec%0d_par_odd", i), int'(op1), int'(!vt[i].exp_p));
                chk($sformatf("vec%0d_count", i), int'(oc0), vt[i].exp_c);
            end
        end

        // Counter saturation on the narrow instance.
        repeat (4) cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, rs);
        chk("sat_no_early_valid", int'(ov0), 0);
        cycle(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, rs);
        chk("sat_count_cw2", int'(oc2), 3);
        chk("sat_parity_cw2", int'(op2), 1);
        chk("sat_count_cw8", int'(oc0), 5);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, rs);

        // Reset in the middle of an open packet, then a clean packet.
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, rs);
        cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, rs);
        async_reset();
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, rs);
        cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, rs);
        chk("post_rst_parity", int'(op0), 1);
        chk("post_rst_count", int'(oc0), 2);

        // Reset while a result is pending drops it.
        cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, rs);
        chk("pending_valid", int'(ov0), 1);
        async_reset();
        chk("dropped_valid", int'(ov0), 0);

        for (int k = 0; k < 600; k++) begin
            cycle(bit'($urandom_range(0, 3) != 0), 8'($urandom),
                  bit'($urandom_range(0, 2) == 0), bit'($urandom),
                  bit'($urandom_range(0, 3) != 0), rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
